// File: rtl/dna_search_ctrl_if.sv
// Configuration, status and sequence-RAM read bus of the DNA search sequencer.
// master = the sequencer, slave = register bank / RAM side.
interface dna_search_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic                  abort;
    logic [31:0]           pattern;
    logic [4:0]            pat_len;
    logic [15:0]           seq_len;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rd_data;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [CNT_WIDTH-1:0]  match_cnt;
    logic [15:0]           first_idx;
    logic                  first_valid;

    modport master (
        input  start, abort, pattern, pat_len, seq_len, mem_rd_data,
        output mem_rd_en, mem_addr, busy, done, error, match_cnt, first_idx, first_valid
    );

    modport slave (
        output start, abort, pattern, pat_len, seq_len, mem_rd_data,
        input  mem_rd_en, mem_addr, busy, done, error, match_cnt, first_idx, first_valid
    );
endinterface

// File: rtl/dna_search_ctrl.sv
// Slides a <=16-base window over 2-bit bases read from a synchronous RAM and counts pattern matches.
// Each 32-bit word costs 2 + bases cycles; no backpressure, only the abort strobe interrupts a search.
module dna_search_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic ACLK,
    input  logic ARESETN,
    dna_search_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           word_dat, window, pat_q;
    logic [4:0]            len_q;
    logic [15:0]           seq_q, k, first;
    logic [3:0]            slot;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  fv, err;

    logic        legal, hit, last_base, word_end;
    logic [31:0] win_nxt, mask;
    logic [5:0]  shamt;
    logic [16:0] k_inc, p_full;

    always_comb begin
        legal     = (bus.pat_len != 5'd0) && (bus.pat_len <= 5'd16);
        win_nxt   = {word_dat[1:0], window[31:2]};
        // newest base sits at the top of the window; align the last len_q bases to bit 0
        shamt     = 6'd32 - {len_q, 1'b0};
        mask      = ~(32'hFFFF_FFFF << {len_q, 1'b0});
        k_inc     = {1'b0, k} + 17'd1;
        p_full    = k_inc - {12'd0, len_q};
        hit       = (k_inc >= {12'd0, len_q}) && (((win_nxt >> shamt) & mask) == (pat_q & mask));
        last_base = (k_inc == {1'b0, seq_q});
        word_end  = (slot == 4'd15) || last_base;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (!legal || bus.seq_len == 16'd0) ? S_DONE : S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_SCAN;
            S_SCAN:  if (word_end) state_nxt = last_base ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= S_IDLE;
            word_addr <= '0;
            word_dat  <= '0;
            window    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            seq_q     <= '0;
            k         <= '0;
            slot      <= '0;
            cnt       <= '0;
            first     <= '0;
            fv        <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (bus.start) begin
                    pat_q     <= bus.pattern;
                    len_q     <= bus.pat_len;
                    seq_q     <= bus.seq_len;
                    word_addr <= '0;
                    window    <= '0;
                    k         <= '0;
                    slot      <= '0;
                    cnt       <= '0;
                    first     <= '0;
                    fv        <= 1'b0;
                    err       <= !legal;
                end
                S_WAIT: word_dat <= bus.mem_rd_data;
                S_SCAN: if (!bus.abort) begin
                    window   <= win_nxt;
                    word_dat <= word_dat >> 2;
                    k        <= k_inc[15:0];
                    slot     <= slot + 4'd1;
                    if (hit) begin
                        if (cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + 1'b1;
                        if (!fv) begin
                            first <= p_full[15:0];
                            fv    <= 1'b1;
                        end
                    end
                    if (word_end) word_addr <= word_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rd_en   = (state == S_FETCH);
    assign bus.mem_addr    = word_addr;
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.error       = err;
    assign bus.match_cnt   = cnt;
    assign bus.first_idx   = first;
    assign bus.first_valid = fv;
endmodule

// File: tb/tb_dna_search_ctrl.sv
// Bench for dna_search_ctrl: two instances (16-bit and 4-bit match counters) run the same
// directed searches against a shared RAM image and a cycle-level reference model.
module tb_dna_search_ctrl;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    dna_search_ctrl_if #(.ADDR_WIDTH(10), .CNT_WIDTH(16)) ifa ();
    dna_search_ctrl_if #(.ADDR_WIDTH(10), .CNT_WIDTH(4))  ifb ();

    dna_search_ctrl #(.ADDR_WIDTH(10), .CNT_WIDTH(16)) dut_a (.ACLK(ACLK), .ARESETN(ARESETN), .bus(ifa.master));
    dna_search_ctrl #(.ADDR_WIDTH(10), .CNT_WIDTH(4))  dut_b (.ACLK(ACLK), .ARESETN(ARESETN), .bus(ifb.master));

    logic [31:0] ram [0:15];
    always @(posedge ACLK) if (ifa.mem_rd_en) ifa.mem_rd_data <= ram[ifa.mem_addr[3:0]];
    always @(posedge ACLK) if (ifb.mem_rd_en) ifb.mem_rd_data <= ram[ifb.mem_addr[3:0]];

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] base_at(input int i);
        logic [31:0] w;
        w = ram[i / 16];
        return w[2 * (i % 16) +: 2];
    endfunction

    function automatic void model_search(input logic [31:0] pat, input int len, input int slen,
                                         output int cnt, output int first);
        bit ok;
        cnt = 0;
        first = -1;
        for (int p = 0; p + len <= slen; p++) begin
            ok = 1'b1;
            for (int j = 0; j < len; j++)
                if (base_at(p + j) != pat[2 * j +: 2]) ok = 1'b0;
            if (ok) begin
                if (first < 0) first = p;
                cnt++;
            end
        end
    endfunction

    // ---------------- reference model + per-cycle comparison ----------------
    bit model_on = 0, act = 0, aborted = 0, rk = 1;
    int t0 = 0, end_cyc = 0;
    int fetch_q[$];
    int p_cnt = 0, p_first = 0, e_cnt = 0, e_first = 0;
    bit p_fv = 0, e_fv = 0, e_err = 0;

    always @(negedge ACLK) begin
        bit busy_e, done_e, rd_e, legal;
        int addr_e, c, rem, b, cnt_b;
        if (model_on) begin
            busy_e = act && cyc > t0 && cyc <= end_cyc;
            done_e = act && !aborted && cyc == end_cyc;
            rd_e = 1'b0;
            addr_e = 0;
            foreach (fetch_q[w]) if (act && fetch_q[w] == cyc && cyc <= end_cyc) begin
                rd_e = 1'b1;
                addr_e = w;
            end
            if (act && !aborted && cyc >= end_cyc && !rk) begin
                rk = 1;
                e_cnt = p_cnt;
                e_first = p_first;
                e_fv = p_fv;
            end
            chk("busy_a", ifa.busy, busy_e);
            chk("busy_b", ifb.busy, busy_e);
            chk("done_a", ifa.done, done_e);
            chk("done_b", ifb.done, done_e);
            chk("rd_en_a", ifa.mem_rd_en, rd_e);
            chk("rd_en_b", ifb.mem_rd_en, rd_e);
            if (rd_e) begin
                chk("addr_a", ifa.mem_addr, addr_e);
                chk("addr_b", ifb.mem_addr, addr_e);
            end
            chk("error_a", ifa.error, e_err);
            chk("error_b", ifb.error, e_err);
            if (rk) begin
                cnt_b = (e_cnt > 15) ? 15 : e_cnt;
                chk("match_cnt_a", ifa.match_cnt, e_cnt);
                chk("match_cnt_b", ifb.match_cnt, cnt_b);
                chk("first_valid_a", ifa.first_valid, e_fv);
                chk("first_valid_b", ifb.first_valid, e_fv);
                if (e_fv) chk("first_idx_a", ifa.first_idx, e_first);
                chk("first_idx_b", ifb.first_idx, e_fv ? e_first : 0);
            end
        end
        if (!ARESETN) begin
            model_on = 1; act = 0; rk = 1;
            e_cnt = 0; e_first = 0; e_fv = 0; e_err = 0;
        end else if (model_on) begin
            if ((!act || cyc > end_cyc) && ifa.start) begin
                act = 1; t0 = cyc; aborted = 0; rk = 0;
                fetch_q.delete();
                legal = ifa.pat_len >= 1 && ifa.pat_len <= 16;
                if (!legal || ifa.seq_len == 0) begin
                    end_cyc = cyc + 1;
                    p_cnt = 0; p_first = 0; p_fv = 0;
                    e_err = !legal;
                end else begin
                    e_err = 0;
                    model_search(ifa.pattern, int'(ifa.pat_len), int'(ifa.seq_len), p_cnt, p_first);
                    p_fv = (p_first >= 0);
                    if (!p_fv) p_first = 0;
                    c = cyc + 1;
                    rem = int'(ifa.seq_len);
                    while (rem > 0) begin
                        b = (rem > 16) ? 16 : rem;
                        fetch_q.push_back(c);
                        c += 2 + b;
                        rem -= b;
                    end
                    end_cyc = c;
                end
            end else if (act && ifa.abort && cyc > t0 && cyc <= end_cyc) begin
                end_cyc = cyc; aborted = 1; rk = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input logic a);
        ifa.start = s; ifb.start = s;
        ifa.abort = a; ifb.abort = a;
    endtask

    task automatic run(input logic [31:0] pat, input logic [4:0] len, input logic [15:0] slen, output int t);
        ifa.pattern = pat;  ifb.pattern = pat;
        ifa.pat_len = len;  ifb.pat_len = len;
        ifa.seq_len = slen; ifb.seq_len = slen;
        @(posedge ACLK); #1;
        drive(1'b1, 1'b0);
        t = cyc;
        @(posedge ACLK); #1;
        drive(1'b0, 1'b0);
    endtask

    task automatic wait_done(input int limit, output int dc);
        bit seen;
        seen = 1'b0;
        dc = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge ACLK);
            if (ifa.done) begin
                seen = 1'b1;
                dc = cyc;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, dc;
        drive(1'b0, 1'b0);
        ifa.pattern = '0; ifb.pattern = '0;
        ifa.pat_len = '0; ifb.pat_len = '0;
        ifa.seq_len = '0; ifb.seq_len = '0;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[0] = 32'hE4E4_E4E4;
        ram[1] = 32'hE4E4_E4E4;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("reset_busy", ifa.busy, 0);
        chk("reset_cnt", ifa.match_cnt, 0);
        chk("reset_rd_en", ifa.mem_rd_en, 0);

        // ACGT repeated, pattern ACGT; extra start pulses while busy must be ignored
        run(32'h0000_00E4, 5'd4, 16'd32, t);
        repeat (4) @(posedge ACLK);
        #1 drive(1'b1, 1'b0);
        @(posedge ACLK); #1 drive(1'b0, 1'b0);
        wait_done(60, dc);
        chk("acgt_done_lat", dc - t, 37);
        chk("acgt_cnt", ifa.match_cnt, 8);
        chk("acgt_first", ifa.first_idx, 0);
        chk("acgt_fv", ifa.first_valid, 1);
        chk("acgt_cnt4", ifb.match_cnt, 8);

        // TACG: one match straddles the word boundary at p=15
        run(32'h0000_0093, 5'd4, 16'd32, t);
        wait_done(60, dc);
        chk("tacg_done_lat", dc - t, 37);
        chk("tacg_cnt", ifa.match_cnt, 7);
        chk("tacg_first", ifa.first_idx, 3);

        // all-A RAM, single-base pattern: 20 matches, 4-bit counter saturates
        ram[0] = 32'h0; ram[1] = 32'h0;
        run(32'h0, 5'd1, 16'd20, t);
        wait_done(60, dc);
        chk("zero_done_lat", dc - t, 25);
        chk("zero_cnt", ifa.match_cnt, 20);
        chk("zero_cnt_sat", ifb.match_cnt, 15);

        // illegal lengths, then a legal start clears error
        ram[0] = 32'hE4E4_E4E4; ram[1] = 32'hE4E4_E4E4;
        run(32'h0000_00E4, 5'd0, 16'd32, t);
        wait_done(10, dc);
        chk("len0_done_lat", dc - t, 1);
        chk("len0_error", ifa.error, 1);
        run(32'h0000_00E4, 5'd17, 16'd32, t);
        wait_done(10, dc);
        chk("len17_done_lat", dc - t, 1);
        chk("len17_error", ifa.error, 1);
        run(32'h0000_00E4, 5'd4, 16'd32, t);
        wait_done(60, dc);
        chk("legal_error_clr", ifa.error, 0);
        chk("legal_cnt", ifa.match_cnt, 8);

        // seq_len == 0 and seq_len < pat_len
        run(32'h0000_00E4, 5'd4, 16'd0, t);
        wait_done(10, dc);
        chk("seq0_done_lat", dc - t, 1);
        chk("seq0_cnt", ifa.match_cnt, 0);
        run(32'h0000_00E4, 5'd4, 16'd3, t);
        wait_done(20, dc);
        chk("short_done_lat", dc - t, 6);
        chk("short_fv", ifa.first_valid, 0);

        // abort mid-search, then restart
        run(32'h0000_00E4, 5'd4, 16'd32, t);
        repeat (9) @(posedge ACLK);
        #1 drive(1'b0, 1'b1);
        @(posedge ACLK); #1 drive(1'b0, 1'b0);
        @(negedge ACLK);
        chk("abort_busy", ifa.busy, 0);
        chk("abort_rd_en", ifa.mem_rd_en, 0);
        repeat (40) @(negedge ACLK);
        run(32'h0000_0093, 5'd4, 16'd32, t);
        wait_done(60, dc);
        chk("restart_cnt", ifa.match_cnt, 7);
        chk("restart_first", ifa.first_idx, 3);

        // synchronous reset in the middle of a search
        run(32'h0000_00E4, 5'd4, 16'd32, t);
        repeat (7) @(posedge ACLK);
        #1 ARESETN = 1'b0;
        @(posedge ACLK); #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_rd_en", ifa.mem_rd_en, 0);
        chk("rst_addr", ifa.mem_addr, 0);
        chk("rst_cnt", ifa.match_cnt, 0);
        chk("rst_fv", ifa.first_valid, 0);
        run(32'h0000_00E4, 5'd4, 16'd32, t);
        wait_done(60, dc);
        chk("post_rst_cnt", ifa.match_cnt, 8);

        repeat (3) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
